// File: rtl/uart_rx.sv
// 8N1-style serial receiver: 2-flop input synchronizer, mid-bit sampling FSM,
// held data register with interrupt/overrun flags acknowledged by the core.
module uart_rx #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned MIN_DIV   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 uart_in,
    input  logic [15:0]          baud_div,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 receiving_interrupt,
    output logic                 frame_error,
    output logic                 overrun
);

    localparam int unsigned    IdxW    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_BITS - 1);
    localparam logic [15:0]    MinDiv  = 16'(MIN_DIV);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e               state_q, state_d;
    logic                 sync1_q, sync2_q;
    logic                 rx_s;
    logic [15:0]          div_q, div_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [15:0]          half;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 fe_q, fe_d;
    logic                 irq_q, irq_d;
    logic                 ovr_q, ovr_d;

    assign rx_s = sync2_q;
    assign half = div_q >> 1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        div_d   = div_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = 1'b0;
        fe_d    = 1'b0;
        irq_d   = irq_q;
        ovr_d   = ovr_q;

        if (rx_ack) begin
            irq_d = 1'b0;
            ovr_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = StStart;
                    div_d   = (baud_div < MinDiv) ? MinDiv : baud_div;
                end
            end
            StStart: begin
                if (cnt_q == half - 16'd1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StData;
                        idx_d   = '0;
                    end
                end
            end
            StData: begin
                if (cnt_q == div_q - 16'd1) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                    if (idx_q == LastIdx) begin
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StStop: begin
                if (cnt_q == div_q - 16'd1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                        irq_d   = 1'b1;
                        // A same-cycle ack consumes the old byte, so no overrun.
                        ovr_d   = rx_ack ? 1'b0 : (ovr_q | irq_q);
                        state_d = StIdle;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = StBreak;
                    end
                end
            end
            StBreak: begin
                cnt_d = '0;
                if (rx_s) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            div_q   <= MinDiv;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            irq_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= uart_in;
            sync2_q <= sync1_q;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            irq_q   <= irq_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_data             = data_q;
    assign rx_valid            = valid_q;
    assign receiving_interrupt = irq_q;
    assign frame_error         = fe_q;
    assign overrun             = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frames are driven bit by bit and a scoreboard predicts each
// stop-sample event (cycle, kind, byte) plus the data/interrupt/overrun state.
module tb_uart_rx;

    localparam int DATA_BITS = 8;
    localparam int MIN_DIV   = 4;

    typedef struct {
        int         cyc;
        bit         good;
        logic [7:0] data;
    } evt_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        uart_in = 1'b1;
    logic [15:0] baud_div = 16'd16;
    logic        rx_ack = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        receiving_interrupt;
    logic        frame_error;
    logic        overrun;

    uart_rx #(.DATA_BITS(DATA_BITS), .MIN_DIV(MIN_DIV)) dut (
        .clk                (clk),
        .reset              (reset),
        .uart_in            (uart_in),
        .baud_div           (baud_div),
        .rx_ack             (rx_ack),
        .rx_data            (rx_data),
        .rx_valid           (rx_valid),
        .receiving_interrupt(receiving_interrupt),
        .frame_error        (frame_error),
        .overrun            (overrun)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic ack_s = 1'b0;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        ack_s <= rx_ack;
    end

    int         n_checks = 0;
    int         n_errors = 0;
    evt_t       exp_q[$];
    logic [7:0] m_data = 8'h00;
    bit         m_int = 1'b0;
    bit         m_ovr = 1'b0;
    int         n_fe_exp = 0;
    int         n_fe_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Runs once per cycle on the falling edge; judges the posedge just passed.
    task automatic monitor_cycle();
        bit         hit;
        bit         eg;
        bit         ef;
        logic [7:0] ed;
        hit = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
        eg  = 1'b0;
        ef  = 1'b0;
        ed  = 8'h00;
        if (hit) begin
            eg = exp_q[0].good;
            ef = !exp_q[0].good;
            ed = exp_q[0].data;
            void'(exp_q.pop_front());
        end
        if (hit || rx_valid || frame_error) begin
            check("rx_valid_pulse", {31'd0, rx_valid}, {31'd0, eg});
            check("frame_error_pulse", {31'd0, frame_error}, {31'd0, ef});
        end
        if (frame_error) n_fe_seen++;
        if (eg) begin
            m_ovr  = ack_s ? 1'b0 : (m_ovr | m_int);
            m_int  = 1'b1;
            m_data = ed;
        end else if (ack_s) begin
            m_int = 1'b0;
            m_ovr = 1'b0;
        end
        if (hit) begin
            check("evt_rx_data", {24'd0, rx_data}, {24'd0, m_data});
            check("evt_irq", {31'd0, receiving_interrupt}, {31'd0, m_int});
            check("evt_overrun", {31'd0, overrun}, {31'd0, m_ovr});
        end
    endtask

    always @(negedge clk) if (!reset) monitor_cycle();

    // Called #1 after a posedge; holds the line for n edges.
    task automatic drive_bit(input logic b, input int n, input int t_ack, input bit rnd);
        uart_in = b;
        for (int i = 0; i < n; i++) begin
            rx_ack = (cyc == t_ack - 1) || (rnd && ($urandom_range(0, 15) == 0));
            @(posedge clk);
            #1;
        end
        rx_ack = 1'b0;
    endtask

    task automatic idle(input int n, input bit rnd);
        drive_bit(1'b1, n, -10, rnd);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop, input int bd,
                              input bit ack_stop, input bit rnd, input bit scramble);
        int dv;
        int c0;
        int t;
        int ta;
        dv = (bd < MIN_DIV) ? MIN_DIV : bd;
        baud_div = 16'(bd);
        c0 = cyc + 1;
        t  = c0 + 2 + dv / 2 + (DATA_BITS + 1) * dv;
        ta = ack_stop ? t : -10;
        exp_q.push_back('{cyc: t, good: stop, data: d});
        if (!stop) n_fe_exp++;
        drive_bit(1'b0, dv, ta, rnd);
        if (scramble) baud_div = 16'($urandom);
        for (int k = 0; k < DATA_BITS; k++) drive_bit(d[k], dv, ta, rnd);
        drive_bit(stop, dv, ta, rnd);
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        @(posedge clk);
        #1;
        rx_ack = 1'b0;
    endtask

    task automatic check_state(input string tag);
        @(negedge clk);
        #1;
        check({tag, "_rx_data"}, {24'd0, rx_data}, {24'd0, m_data});
        check({tag, "_irq"}, {31'd0, receiving_interrupt}, {31'd0, m_int});
        check({tag, "_overrun"}, {31'd0, overrun}, {31'd0, m_ovr});
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rx_data"}, {24'd0, rx_data}, 32'd0);
        check({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
        check({tag, "_irq"}, {31'd0, receiving_interrupt}, 32'd0);
        check({tag, "_frame_error"}, {31'd0, frame_error}, 32'd0);
        check({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] rd;
        bit         st;

        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset = 1'b0;
        idle(5, 1'b0);

        // Basic byte at div 16
        send_frame(8'hA5, 1'b1, 16, 1'b0, 1'b0, 1'b0);
        idle(4, 1'b0);
        check_state("a5_held");
        check("a5_data", {24'd0, rx_data}, 32'hA5);
        ack_pulse();
        check_state("a5_acked");

        // False start: 5 low clocks
        drive_bit(1'b0, 5, -10, 1'b0);
        idle(40, 1'b0);
        check_state("false_start");
        send_frame(8'h3C, 1'b1, 16, 1'b0, 1'b0, 1'b0);
        idle(4, 1'b0);
        check_state("3c");
        ack_pulse();

        // Framing error then line held low for 40 bit times
        send_frame(8'h55, 1'b0, 16, 1'b0, 1'b0, 1'b0);
        drive_bit(1'b0, 40 * 16, -10, 1'b0);
        idle(16, 1'b0);
        check_state("after_break");
        send_frame(8'h81, 1'b1, 16, 1'b0, 1'b0, 1'b0);
        idle(4, 1'b0);
        check_state("81");
        ack_pulse();

        // Overrun, back-to-back
        send_frame(8'h11, 1'b1, 16, 1'b0, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 16, 1'b0, 1'b0, 1'b0);
        idle(4, 1'b0);
        check("ovr_data", {24'd0, rx_data}, 32'h22);
        check("ovr_set", {31'd0, overrun}, 32'd1);
        check_state("ovr");
        ack_pulse();
        check_state("ovr_acked");

        // Ack on the stop-sample edge of the second byte
        send_frame(8'h11, 1'b1, 16, 1'b0, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 16, 1'b1, 1'b0, 1'b0);
        idle(4, 1'b0);
        check("ackstop_irq", {31'd0, receiving_interrupt}, 32'd1);
        check("ackstop_ovr", {31'd0, overrun}, 32'd0);
        check_state("ackstop");
        ack_pulse();

        // Divisor clamp
        send_frame(8'hFF, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        send_frame(8'h00, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        idle(4, 1'b0);
        check_state("clamp");
        ack_pulse();

        // Randomized frames, divisors, gaps, acks and mid-frame divisor changes
        for (int i = 0; i < 40; i++) begin
            d  = 8'($urandom);
            st = ($urandom_range(0, 7) != 0);
            send_frame(d, st, $urandom_range(0, 24), 1'b0, 1'b1, 1'($urandom_range(0, 1)));
            if (st) idle($urandom_range(0, 3), 1'b1);
            else    idle($urandom_range(1, 30), 1'b1);
        end
        idle(10, 1'b0);
        check_state("random_end");

        // Reset in the middle of data bit 3
        send_frame(8'hC3, 1'b1, 16, 1'b0, 1'b0, 1'b0);
        idle(4, 1'b0);
        rd = 8'h5A;
        baud_div = 16'd16;
        drive_bit(1'b0, 16, -10, 1'b0);
        for (int k = 0; k < 3; k++) drive_bit(rd[k], 16, -10, 1'b0);
        uart_in = rd[3];
        repeat (8) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_outputs_zero("midreset");
        exp_q.delete();
        m_data = 8'h00;
        m_int  = 1'b0;
        m_ovr  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        uart_in = 1'b1;
        reset = 1'b0;
        idle(5, 1'b0);
        send_frame(8'h5A, 1'b1, 16, 1'b0, 1'b0, 1'b0);
        idle(4, 1'b0);
        check("post_reset_data", {24'd0, rx_data}, 32'h5A);
        check_state("post_reset");

        idle(30, 1'b0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("frame_error_count", 32'(n_fe_seen), 32'(n_fe_exp));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
